// File: rtl/ins_seq_ctrl.sv
// ins_seq_ctrl: multi-cycle RV32I fetch/decode/execute/writeback sequencer owning the PC.
// Optional INS_SEQ_CTRL_MISALIGN_TRAP_EN traps on PC targets with bit 1 set.
module ins_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] ins,
    output logic        exec_op,
    output logic [31:0] reg_pc_val,
    input  logic        ex_pc_w_op,
    input  logic [31:0] ex_pc_w_val,
    input  logic        ex_reg_w_op,
    input  logic [4:0]  ex_reg_w_idx,
    input  logic [31:0] ex_reg_w_val,
    output logic        rf_w_en,
    output logic [4:0]  rf_w_idx,
    output logic [31:0] rf_w_val,
    output logic        busy,
    output logic        trap,
    output logic [31:0] instret
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_e;
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ins_q, ins_d, instret_q, instret_d;
    logic        trap_q, trap_d, exec_op_q, rf_w_en_q;
    logic        pcw_op_q;
    logic [31:0] pcw_val_q, rw_val_q;
    logic [4:0]  rw_idx_q;
    logic        misalign;
`ifdef INS_SEQ_CTRL_MISALIGN_TRAP_EN
    assign misalign = pcw_op_q & pcw_val_q[1];
`else
    assign misalign = 1'b0;
`endif
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ins_d     = ins_q;
        instret_d = instret_q;
        trap_d    = trap_q;
        case (state_q)
            IDLE:   if (start) state_d = FETCH;
            FETCH:  begin
                if (imem_ack) begin
                    ins_d   = imem_data;
                    state_d = DECODE;
                end else if (halt_req) state_d = HALT;
            end
            DECODE: state_d = EXEC;
            EXEC:   state_d = WB;
            WB:     begin
                if (misalign) begin
                    trap_d  = 1'b1;
                    state_d = HALT;
                end else begin
                    pc_d      = pcw_op_q ? (pcw_val_q & ~32'h1) : pc_q + 32'd4;
                    instret_d = instret_q + 32'd1;
                    state_d   = halt_req ? HALT : FETCH;
                end
            end
            HALT:   begin
                if (start) begin
                    trap_d  = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            ins_q     <= 32'h0000_0013;
            instret_q <= '0;
            trap_q    <= 1'b0;
            exec_op_q <= 1'b0;
            rf_w_en_q <= 1'b0;
            pcw_op_q  <= 1'b0;
            pcw_val_q <= '0;
            rw_idx_q  <= '0;
            rw_val_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ins_q     <= ins_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
            exec_op_q <= (state_d == EXEC);
            // WB holding registers: the execute units' outputs are only valid during EXEC
            rf_w_en_q <= (state_q == EXEC) & ex_reg_w_op & (ex_reg_w_idx != 5'd0);
            if (state_q == EXEC) begin
                pcw_op_q  <= ex_pc_w_op;
                pcw_val_q <= ex_pc_w_val;
                rw_idx_q  <= ex_reg_w_idx;
                rw_val_q  <= ex_reg_w_val;
            end
        end
    end
    assign imem_req   = (state_q == FETCH);
    assign busy       = (state_q != IDLE) && (state_q != HALT);
    assign ins        = ins_q;
    assign exec_op    = exec_op_q;
    assign reg_pc_val = pc_q;
    assign rf_w_en    = rf_w_en_q;
    assign rf_w_idx   = rw_idx_q;
    assign rf_w_val   = rw_val_q;
    assign trap       = trap_q;
    assign instret    = instret_q;
endmodule

// File: tb/tb_ins_seq_ctrl.sv
// tb_ins_seq_ctrl: randomized bench for ins_seq_ctrl against an instruction-level PC/retire model.
module tb_ins_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, halt_req, imem_req, imem_ack, exec_op;
    logic [31:0] imem_data, ins, reg_pc_val, ex_pc_w_val, ex_reg_w_val, rf_w_val, instret;
    logic        ex_pc_w_op, ex_reg_w_op, rf_w_en, busy, trap;
    logic [4:0]  ex_reg_w_idx, rf_w_idx;
    int          vectors = 0, errors = 0;
    logic [31:0] m_pc, m_ret;
    logic        m_trap, m_halted;

    ins_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data), .ins(ins),
        .exec_op(exec_op), .reg_pc_val(reg_pc_val),
        .ex_pc_w_op(ex_pc_w_op), .ex_pc_w_val(ex_pc_w_val), .ex_reg_w_op(ex_reg_w_op),
        .ex_reg_w_idx(ex_reg_w_idx), .ex_reg_w_val(ex_reg_w_val),
        .rf_w_en(rf_w_en), .rf_w_idx(rf_w_idx), .rf_w_val(rf_w_val),
        .busy(busy), .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic clear_ex();
        ex_pc_w_op = 0; ex_pc_w_val = 0; ex_reg_w_op = 0; ex_reg_w_idx = 0; ex_reg_w_val = 0;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; halt_req = 0; imem_ack = 0; imem_data = 0;
        clear_ex();
        m_pc = 32'h0; m_ret = 0; m_trap = 0; m_halted = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if (reg_pc_val !== 32'h0 || ins !== 32'h13 || instret !== 0 || trap !== 0) begin
            errors++;
            $display("FAIL reset_regs pc=%h ins=%h ret=%0d trap=%b, need 0/00000013/0/0", reg_pc_val, ins, instret, trap);
        end
        vectors++;
        if (imem_req !== 0 || exec_op !== 0 || rf_w_en !== 0 || rf_w_idx !== 0 || rf_w_val !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL reset_outs req=%b op=%b we=%b idx=%0d val=%h busy=%b, need all 0", imem_req, exec_op, rf_w_en, rf_w_idx, rf_w_val, busy);
        end
        rst = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 0 || imem_req !== 0) begin
            errors++;
            $display("FAIL idle_hold busy=%b req=%b, need 0 0", busy, imem_req);
        end
    endtask

    // Enter FETCH from IDLE or HALT; the sticky trap is cleared on restart.
    task automatic do_start();
        start = 1;
        @(negedge clk);
        start = 0;
        m_trap = 0; m_halted = 0;
        vectors++;
        if (busy !== 1 || imem_req !== 1 || trap !== 0 || reg_pc_val !== m_pc) begin
            errors++;
            $display("FAIL start busy=%b req=%b trap=%b pc=%h, need 1 1 0 %h", busy, imem_req, trap, reg_pc_val, m_pc);
        end
    endtask

    // One full instruction, entered at the negedge of its first FETCH cycle.
    task automatic run_instr(input int dly, input logic pcw, input logic [31:0] pcv, input logic rw,
                             input logic [4:0] idx, input logic [31:0] val, input logic hwb);
        logic [31:0] d;
        logic        mis, exp_we;
        d = $urandom;
        for (int i = 0; i <= dly; i++) begin
            vectors++;
            if (imem_req !== 1 || busy !== 1 || reg_pc_val !== m_pc) begin
                errors++;
                $display("FAIL fetch[%0d] req=%b busy=%b pc=%h, need 1 1 %h", i, imem_req, busy, reg_pc_val, m_pc);
            end
            imem_ack = (i == dly); imem_data = (i == dly) ? d : $urandom;
            halt_req = 0; start = 1'($urandom);
            @(negedge clk);
        end
        imem_ack = 0; halt_req = 1'($urandom); start = 1'($urandom);
        vectors++;
        if (ins !== d || imem_req !== 0 || exec_op !== 0 || busy !== 1) begin
            errors++;
            $display("FAIL decode ins=%h req=%b op=%b busy=%b, need %h 0 0 1", ins, imem_req, exec_op, busy, d);
        end
        @(negedge clk);
        vectors++;
        if (exec_op !== 1) begin
            errors++;
            $display("FAIL exec_op got %b need 1", exec_op);
        end
        ex_pc_w_op = pcw; ex_pc_w_val = pcw ? pcv : 32'h0;
        ex_reg_w_op = rw; ex_reg_w_idx = idx; ex_reg_w_val = val;
        @(negedge clk);
        clear_ex();
        halt_req = hwb; start = 1'($urandom);
        exp_we = rw && (idx != 0);
        vectors++;
        if (exec_op !== 0 || rf_w_en !== exp_we || (exp_we && (rf_w_idx !== idx || rf_w_val !== val))) begin
            errors++;
            $display("FAIL wb_write op=%b we=%b idx=%0d val=%h, need 0 %b %0d %h", exec_op, rf_w_en, rf_w_idx, rf_w_val, exp_we, idx, val);
        end
`ifdef INS_SEQ_CTRL_MISALIGN_TRAP_EN
        mis = pcw && pcv[1];
`else
        mis = 0;
`endif
        if (mis) begin
            m_trap = 1; m_halted = 1;
        end else begin
            m_pc = pcw ? (pcv & ~32'h1) : m_pc + 32'd4;
            m_ret = m_ret + 1;
            m_halted = hwb;
        end
        @(negedge clk);
        halt_req = 0; start = 0;
        vectors++;
        if (reg_pc_val !== m_pc || instret !== m_ret || trap !== m_trap || busy !== !m_halted || rf_w_en !== 0) begin
            errors++;
            $display("FAIL commit pc=%h ret=%0d trap=%b busy=%b we=%b, need %h %0d %b %b 0", reg_pc_val, instret, trap, busy, rf_w_en, m_pc, m_ret, m_trap, !m_halted);
        end
        if (m_halted) begin
            @(negedge clk);
            vectors++;
            if (busy !== 0 || imem_req !== 0 || reg_pc_val !== m_pc) begin
                errors++;
                $display("FAIL halt_hold busy=%b req=%b pc=%h, need 0 0 %h", busy, imem_req, reg_pc_val, m_pc);
            end
            do_start();
        end
    endtask

    task automatic test_addi_stream();
        do_start();
        for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 1, 5'(i + 1), 32'(i * 3), 0);
    endtask

    task automatic test_jalr();
        run_instr(0, 1, 32'h0000_0101, 1, 5'd5, 32'd8, 0);
    endtask

    task automatic test_x0();
        run_instr(0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_ack_delay();
        run_instr(3, 0, 0, 0, 5'd9, 32'h1234, 0);
    endtask

    task automatic test_misalign();
        run_instr(0, 1, 32'h0000_0102, 1, 5'd3, 32'h55, 0);
    endtask

    task automatic test_pc_wrap();
        run_instr(1, 1, 32'hFFFF_FFFD, 0, 5'd0, 0, 0);
        run_instr(0, 0, 0, 1, 5'd31, 32'hA5A5_A5A5, 0);
    endtask

    task automatic test_wb_halt();
        run_instr(0, 0, 0, 1, 5'd4, 32'h7, 1);
    endtask

    task automatic test_fetch_halt();
        imem_ack = 0; halt_req = 1;
        @(negedge clk);
        halt_req = 0;
        vectors++;
        if (busy !== 0 || imem_req !== 0 || reg_pc_val !== m_pc || instret !== m_ret) begin
            errors++;
            $display("FAIL fetch_halt busy=%b req=%b pc=%h ret=%0d, need 0 0 %h %0d", busy, imem_req, reg_pc_val, instret, m_pc, m_ret);
        end
        do_start();
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++)
            run_instr($urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom, 1'($urandom),
                      5'($urandom), $urandom, $urandom_range(0, 7) == 0);
    endtask

    task automatic test_reset_exec();
        imem_ack = 1; imem_data = 32'h0010_0093;
        @(negedge clk);
        imem_ack = 0;
        @(negedge clk);
        ex_pc_w_op = 1; ex_pc_w_val = 32'h40; ex_reg_w_op = 1; ex_reg_w_idx = 7; ex_reg_w_val = 9;
        #2 rst = 1;
        #1;
        m_pc = 0; m_ret = 0; m_trap = 0;
        vectors++;
        if (reg_pc_val !== m_pc || rf_w_en !== 0 || instret !== 0 || busy !== 0 || exec_op !== 0) begin
            errors++;
            $display("FAIL reset_exec pc=%h we=%b ret=%0d busy=%b op=%b, need %h 0 0 0 0", reg_pc_val, rf_w_en, instret, busy, exec_op, m_pc);
        end
        @(negedge clk);
        rst = 0;
        clear_ex();
        @(negedge clk);
        vectors++;
        if (reg_pc_val !== m_pc || rf_w_en !== 0 || instret !== 0 || busy !== 0 || ins !== 32'h13) begin
            errors++;
            $display("FAIL reset_exec_after pc=%h we=%b ret=%0d busy=%b ins=%h, need %h 0 0 0 00000013", reg_pc_val, rf_w_en, instret, busy, ins, m_pc);
        end
    endtask

    initial begin
        test_reset();
        test_addi_stream();
        test_jalr();
        test_x0();
        test_ack_delay();
        test_misalign();
        test_pc_wrap();
        test_wb_halt();
        test_fetch_halt();
        test_random();
        run_instr(0, 0, 0, 0, 0, 0, 0);
        test_reset_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ins_seq_ctrl.md
# ins_seq_ctrl

Multi-cycle instruction sequencer for the RV32I core. It owns the architectural PC and steps each instruction through fetch, decode, execute and writeback. During execute it raises a single `op` strobe to all execute units (`InsExec_RV32I_*`). It then arbitrates their OR-combined PC-write and register-write requests into one PC update and one register-file write port per instruction.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1: core clock, rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: leave IDLE and begin fetching at the current PC.
- `halt_req`  in  1: stop at the next instruction boundary.
- `imem_req`  out  1: fetch request; the address is `reg_pc_val`.
- `imem_ack`  in  1: fetch data valid this cycle.
- `imem_data`  in  32: fetched instruction.
- `ins`  out  32: latched instruction, fed to the decoder.
- `exec_op`  out  1: execute strobe to all execute units.
- `reg_pc_val`  out  32: architectural PC.
- `ex_pc_w_op`  in  1: OR of the units' `reg_pc_w_op` outputs.
- `ex_pc_w_val`  in  32: OR of the units' `reg_pc_w_val` outputs (inactive units drive 0).
- `ex_reg_w_op`  in  1: OR of the units' `reg_w_op` outputs.
- `ex_reg_w_idx`  in  5: OR of the units' `reg_w_reg_idx` outputs.
- `ex_reg_w_val`  in  32: OR of the units' `reg_w_reg_val` outputs.
- `rf_w_en`  out  1: register-file write enable.
- `rf_w_idx`  out  5: register-file write index.
- `rf_w_val`  out  32: register-file write data.
- `busy`  out  1: high in every state except IDLE and HALT.
- `trap`  out  1: sticky misaligned-target trap flag.
- `instret`  out  32: retired-instruction counter.

## Operation
States:
- IDLE:
  - `start` -> FETCH.
- FETCH:
  - `imem_req` is held high.
  - On `imem_ack`: latch `imem_data` into `ins`, then go to DECODE.
  - If `halt_req` is high and `imem_ack` is low -> HALT. The fetch is abandoned and the PC is unchanged.
- DECODE:
  - One cycle; the decoder settles on `ins`.
  - -> EXEC.
- EXEC:
  - `exec_op` is high for exactly this one cycle.
  - At the end of the cycle, capture all five `ex_*` inputs into WB holding registers.
  - -> WB.
- WB:
  - Register write: `rf_w_en` = captured `reg_w_op` AND idx != 0. Writes to x0 are suppressed.
  - PC update: if captured `pc_w_op`, PC <= `pc_w_val & ~32'h1` (the JALR LSB clear is done here). Otherwise PC <= PC + 4, wrapping modulo 2^32.
  - `instret` increments by 1 and wraps from 32'hFFFF_FFFF to 0.
  - Next state: `halt_req` -> HALT; otherwise -> FETCH.
- HALT:
  - Stays in HALT until `start`, which goes to FETCH. `start` clears `trap`.

Reset values:
- State is IDLE.
- `reg_pc_val` = `RESET_PC`.
- `ins` = 32'h0000_0013 (NOP).
- `instret`, `trap`, `imem_req`, `exec_op`, `rf_w_en`, `rf_w_idx`, `rf_w_val` and the WB holding registers are all 0.

Boundary rules:
- `start` is ignored outside IDLE and HALT.
- `halt_req` is sampled only in FETCH and WB.
- Reset asserted mid-instruction discards that instruction. No register-file write and no PC change happen, and `instret` is not incremented.

## Timing
- Minimum cycles per instruction: 4 (FETCH with same-cycle ack, DECODE, EXEC, WB). Each cycle of `imem_ack` delay adds one cycle.
- `imem_req` is a combinational decode of state == FETCH.
- `rf_w_*` are registered: they are valid during the WB cycle, and the register file writes on the WB-to-next-state clock edge.
- The new PC is visible the cycle after WB, which is the first FETCH cycle of the next instruction.
- `exec_op` is registered from the state, so it is a one-cycle pulse aligned with EXEC.

## Configuration
`INS_SEQ_CTRL_MISALIGN_TRAP_EN`:
- Defined: in WB, if captured `pc_w_op` is set and `pc_w_val[1]` is 1, then:
  - set `trap`;
  - do not update the PC;
  - still perform the register write;
  - do not increment `instret`;
  - -> HALT.
- Undefined: bit 1 is ignored, the target (with bit 0 cleared) is committed normally, and `trap` stays 0.

## Test plan
- Reset, `start`, ack held at 1, ADDI stream with no PC write:
  - PC goes 0 -> 4 -> 8.
  - `instret` increments every 4 cycles.
  - `exec_op` is high for 1 of every 4 cycles.
- JALR in EXEC: `ex_pc_w_op`=1, `ex_pc_w_val`=32'h0000_0101, `ex_reg_w_idx`=5, `ex_reg_w_val`=8:
  - `rf_w_en`=1, idx 5, val 8.
  - Next PC = 32'h0000_0100.
- `ex_reg_w_op`=1 with idx 0:
  - `rf_w_en` stays 0.
  - PC advances by 4.
- `imem_ack` delayed 3 cycles:
  - `imem_req` is held high for 4 cycles and `ins` latches on the ack cycle.
  - The instruction takes 7 cycles in total.
- `ex_pc_w_val`=32'h0000_0102:
  - With the macro: `trap`=1, state HALT, PC unchanged, register write done, `instret` unchanged.
  - Without the macro: PC = 32'h0000_0102.
- `rst` asserted during EXEC:
  - Next cycle: PC = `RESET_PC`, `rf_w_en`=0, `instret`=0, state IDLE.
  - `halt_req` in WB: next state HALT, `busy`=0.
